// File: rtl/dcache_pkg.sv
// Shared types and widths for the L1 data cache.
// Widths below describe the default 16-line, 4-word geometry.
package dcache_pkg;

    localparam int DATA_W    = 32;
    localparam int DEF_LINES = 16;
    localparam int DEF_WORDS = 4;
    localparam int OFF_W     = 2;
    localparam int WORD_W    = $clog2(DEF_WORDS);
    localparam int IDX_W     = $clog2(DEF_LINES);
    localparam int TAG_W     = DATA_W - IDX_W - WORD_W - OFF_W;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_HI   = 4'b1100;
    localparam logic [3:0] BE_LO   = 4'b0011;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        WRITE,
        WDONE
    } state_t;

endpackage

// File: rtl/l1_dcache_if.sv
// Word-wide main-memory port of the L1 data cache.
// One mem_ready pulse completes each request.
interface l1_dcache_if #(
    parameter int DW = 32
);

    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_be;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ready
    );

endinterface

// File: rtl/dcache_data_array.sv
// Line data storage: combinational read, byte-enabled synchronous write.
module dcache_data_array #(
    parameter int DW    = 32,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [3:0]    be,
    input  logic [DW-1:0] wdata
);

    logic [DW-1:0] mem [DEPTH];

    assign rdata = mem[raddr];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped write-through, no-write-allocate L1 data cache.
// Define DCACHE_STATS_EN to build the load hit/miss counters.
module l1_dcache
    import dcache_pkg::*;
#(
    parameter int data_size = DATA_W,
    parameter int LINES     = DEF_LINES,
    parameter int WORDS     = DEF_WORDS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_read,
    input  logic                 cpu_write,
    input  logic                 cpu_lh,
    input  logic                 cpu_sh,
    input  logic [data_size-1:0] cpu_addr,
    input  logic [data_size-1:0] cpu_wdata,
    output logic [data_size-1:0] cpu_rdata,
    output logic                 stall,
    l1_dcache_if.master          mem,
    output logic [31:0]          hit_cnt,
    output logic [31:0]          miss_cnt
);

    localparam int WW = $clog2(WORDS);
    localparam int IW = $clog2(LINES);
    localparam int TW = data_size - IW - WW - OFF_W;
    localparam int HW = data_size / 2;

    state_t state, state_n;

    logic [WW-1:0]        cnt;
    logic [LINES-1:0]     valid;
    logic [TW-1:0]        tags [LINES];
    logic [WW-1:0]        word_sel;
    logic [IW-1:0]        idx;
    logic [TW-1:0]        tag;
    logic                 hit;
    logic [data_size-1:0] rd_word;
    logic [HW-1:0]        rd_half;
    logic [3:0]           st_be;
    logic [data_size-1:0] st_data;
    logic                 arr_we;
    logic [WW-1:0]        arr_word;
    logic [3:0]           arr_be;
    logic [data_size-1:0] arr_wdata;
    logic                 fill_done;
    logic                 unused_ok;

    assign word_sel  = cpu_addr[OFF_W +: WW];
    assign idx       = cpu_addr[OFF_W+WW +: IW];
    assign tag       = cpu_addr[data_size-1 -: TW];
    assign hit       = valid[idx] && (tags[idx] == tag);
    assign unused_ok = cpu_addr[0];

    assign st_be   = cpu_sh ? (cpu_addr[1] ? BE_HI : BE_LO) : BE_WORD;
    assign st_data = cpu_sh ? {2{cpu_wdata[HW-1:0]}} : cpu_wdata;

    dcache_data_array #(
        .DW    (data_size),
        .DEPTH (LINES * WORDS),
        .AW    (IW + WW)
    ) u_data (
        .clk   (clk),
        .raddr ({idx, word_sel}),
        .rdata (rd_word),
        .we    (arr_we),
        .waddr ({idx, arr_word}),
        .be    (arr_be),
        .wdata (arr_wdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            valid <= '0;
        end else begin
            state <= state_n;
            if (state == REFILL && mem.mem_ready) begin
                cnt <= fill_done ? '0 : cnt + 1'b1;
            end
            if (fill_done) valid[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_done) tags[idx] <= tag;
    end

    always_comb begin
        state_n       = state;
        stall         = 1'b0;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        mem.mem_be    = '0;
        arr_we        = 1'b0;
        arr_word      = word_sel;
        arr_be        = BE_WORD;
        arr_wdata     = mem.mem_rdata;
        fill_done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (cpu_write) begin
                    stall   = 1'b1;
                    state_n = WRITE;
                end else if (cpu_read && !hit) begin
                    stall   = 1'b1;
                    state_n = REFILL;
                end
            end
            REFILL: begin
                stall        = 1'b1;
                mem.mem_req  = 1'b1;
                mem.mem_addr = {tag, idx, cnt, 2'b00};
                if (mem.mem_ready) begin
                    arr_we   = 1'b1;
                    arr_word = cnt;
                    if (cnt == WW'(WORDS - 1)) begin
                        fill_done = 1'b1;
                        state_n   = IDLE;
                    end
                end
            end
            WRITE: begin
                stall         = 1'b1;
                mem.mem_req   = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_addr  = {cpu_addr[data_size-1:OFF_W], 2'b00};
                mem.mem_wdata = st_data;
                mem.mem_be    = st_be;
                if (mem.mem_ready) begin
                    // Write-through: only refresh the cached copy on a hit
                    arr_we    = hit;
                    arr_be    = st_be;
                    arr_wdata = st_data;
                    state_n   = WDONE;
                end
            end
            WDONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (rst) begin
            stall         = 1'b0;
            mem.mem_req   = 1'b0;
            mem.mem_we    = 1'b0;
            mem.mem_addr  = '0;
            mem.mem_wdata = '0;
            mem.mem_be    = '0;
            arr_we        = 1'b0;
            fill_done     = 1'b0;
        end
    end

    always_comb begin
        rd_half   = cpu_addr[1] ? rd_word[data_size-1:HW] : rd_word[HW-1:0];
        cpu_rdata = '0;
        if (cpu_read && hit && !rst) begin
            cpu_rdata = cpu_lh ? {{HW{rd_half[HW-1]}}, rd_half} : rd_word;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hits_q;
    logic [31:0] misses_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            if (state == IDLE && cpu_read && !cpu_write && hit) begin
                hits_q <= hits_q + 1'b1;
            end
            if (state == IDLE && state_n == REFILL) begin
                misses_q <= misses_q + 1'b1;
            end
        end
    end

    assign hit_cnt  = hits_q;
    assign miss_cnt = misses_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_l1_dcache.sv
// Directed bench for l1_dcache with a 2-cycle-latency memory model.
module tb_l1_dcache;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic        cpu_lh = 1'b0;
    logic        cpu_sh = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int n_chk = 0;
    int n_err = 0;

    l1_dcache_if #(.DW(32)) m();

    l1_dcache dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_lh    (cpu_lh),
        .cpu_sh    (cpu_sh),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .stall     (stall),
        .mem       (m),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    always #5 clk = ~clk;

    // Memory model: unwritten words read as addr ^ 0x5A5A0000
    logic [31:0] ram [1024];
    int          lat = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] rd_log [64];
    logic [31:0] wa_last = '0;
    logic [31:0] wd_last = '0;
    logic [3:0]  wbe_last = '0;

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [3:0] be,
                                          input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            lat         <= 0;
            m.mem_ready <= 1'b0;
            m.mem_rdata <= '0;
            for (int i = 0; i < 1024; i++) begin
                ram[i] <= {20'd0, 10'(i), 2'b00} ^ 32'h5A5A0000;
            end
            ram[16] <= 32'h11;
            ram[17] <= 32'h22;
            ram[18] <= 32'h33;
            ram[19] <= 32'h44;
        end else begin
            m.mem_ready <= 1'b0;
            if (m.mem_req && m.mem_ready) begin
                if (m.mem_we) begin
                    ram[m.mem_addr[11:2]] <= merge(ram[m.mem_addr[11:2]],
                                                   m.mem_be, m.mem_wdata);
                    wr_cnt   <= wr_cnt + 1;
                    wa_last  <= m.mem_addr;
                    wd_last  <= m.mem_wdata;
                    wbe_last <= m.mem_be;
                end else begin
                    rd_log[rd_cnt[5:0]] <= m.mem_addr;
                    rd_cnt <= rd_cnt + 1;
                end
            end else if (m.mem_req) begin
                if (lat == 1) begin
                    m.mem_ready <= 1'b1;
                    m.mem_rdata <= ram[m.mem_addr[11:2]];
                    lat         <= 0;
                end else begin
                    lat <= lat + 1;
                end
            end else begin
                lat <= 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [31:0] a, input logic lh,
                        input logic [31:0] exp, input int exp_cyc,
                        input string tag);
        int cyc = 0;
        @(negedge clk);
        cpu_read = 1'b1;
        cpu_lh   = lh;
        cpu_addr = a;
        #1;
        while (stall && cyc < 200) begin
            cyc++;
            @(negedge clk);
            #1;
        end
        chk({tag, "_cyc"}, 32'(cyc), 32'(exp_cyc));
        chk({tag, "_data"}, cpu_rdata, exp);
        chk({tag, "_req"}, {31'd0, m.mem_req}, 32'd0);
        @(posedge clk);
        #1;
        cpu_read = 1'b0;
        cpu_lh   = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d,
                         input logic sh, input string tag);
        int cyc = 0;
        @(negedge clk);
        cpu_write = 1'b1;
        cpu_sh    = sh;
        cpu_addr  = a;
        cpu_wdata = d;
        #1;
        while (stall && cyc < 200) begin
            cyc++;
            @(negedge clk);
            #1;
        end
        chk({tag, "_cyc"}, 32'(cyc), 32'd4);
        @(posedge clk);
        #1;
        cpu_write = 1'b0;
        cpu_sh    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int cyc;

        cpu_read = 1'b1;
        cpu_addr = 32'h40;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_req", {31'd0, m.mem_req}, 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_hits", hit_cnt, 32'd0);
        chk("rst_miss", miss_cnt, 32'd0);
        cpu_read = 1'b0;
        rst = 1'b0;

        load(32'h40, 1'b0, 32'h11, 13, "cold");
        chk("cold_nrd", 32'(rd_cnt), 32'd4);
        chk("cold_a0", rd_log[0], 32'h40);
        chk("cold_a1", rd_log[1], 32'h44);
        chk("cold_a3", rd_log[3], 32'h4C);

        load(32'h4C, 1'b0, 32'h44, 0, "hit4c");

        store(32'h4A, 32'h8001, 1'b1, "sh");
        chk("sh_nwr", 32'(wr_cnt), 32'd1);
        chk("sh_addr", wa_last, 32'h48);
        chk("sh_be", {28'd0, wbe_last}, 32'hC);
        chk("sh_wd", wd_last, 32'h80018001);

        load(32'h4A, 1'b1, 32'hFFFF8001, 0, "lh_hi");
        load(32'h48, 1'b1, 32'h00000033, 0, "lh_lo");
        load(32'h48, 1'b0, 32'h80010033, 0, "lw48");

        store(32'h400, 32'hDEADBEEF, 1'b0, "sw");
        chk("sw_nwr", 32'(wr_cnt), 32'd2);
        chk("sw_addr", wa_last, 32'h400);
        chk("sw_be", {28'd0, wbe_last}, 32'hF);
        chk("sw_wd", wd_last, 32'hDEADBEEF);
        load(32'h400, 1'b0, 32'hDEADBEEF, 13, "ld400");

        load(32'h40, 1'b0, 32'h11, 0, "hit40");
        load(32'h140, 1'b0, 32'h5A5A0140, 13, "evict");
        load(32'h40, 1'b0, 32'h11, 13, "reload");
        load(32'h48, 1'b0, 32'h80010033, 0, "lw48b");

        base = rd_cnt;
        cyc  = 0;
        @(negedge clk);
        cpu_read = 1'b1;
        cpu_addr = 32'h140;
        while (rd_cnt < base + 2 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        chk("mid_words", 32'(rd_cnt - base), 32'd2);
`ifdef DCACHE_STATS_EN
        chk("mid_misses", miss_cnt, 32'd5);
`endif
        #1;
        rst = 1'b1;
        #1;
        chk("arst_req", {31'd0, m.mem_req}, 32'd0);
        chk("arst_stall", {31'd0, stall}, 32'd0);
        chk("arst_rdata", cpu_rdata, 32'd0);
        chk("arst_hits", hit_cnt, 32'd0);
        chk("arst_miss", miss_cnt, 32'd0);
        cpu_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        load(32'h140, 1'b0, 32'h5A5A0140, 13, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
